coord_intersect: RTL

- Downstream consumer of two scanner instances in the sparse-tensor datapath.
- Each scanner streams the nonzeros of one fiber, a row or a column of a SparseMatrixTree, as (coordinate, value) pairs in strictly ascending coordinate order.
- This block performs the coordinate-intersection step: it emits only pairs whose coordinate is present in both streams, and accumulates the dot product of the matched values.
- Its output feeds the downstream multiply/accumulate or writeback stage.

---
 rtl/coord_intersect.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/coord_intersect.sv
// Coordinate intersection of two ascending sparse fiber streams.
// Emits matched (coord, a, b) pairs and keeps a running dot product and match count.
module coord_intersect #(
    parameter int unsigned CW   = 16,
    parameter int unsigned DW   = 16,
    parameter int unsigned ACCW = 40,
    parameter int unsigned CNTW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [CW-1:0]   a_coord,
    input  logic [DW-1:0]   a_value,
    input  logic            a_last,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [CW-1:0]   b_coord,
    input  logic [DW-1:0]   b_value,
    input  logic            b_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   out_coord,
    output logic [DW-1:0]   out_a_value,
    output logic [DW-1:0]   out_b_value,
    output logic [ACCW-1:0] dot_sum,
    output logic [CNTW-1:0] match_count,
    output logic            done
);

    localparam int unsigned PW = 2 * DW;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_DRAIN_A = 3'd2,
        S_DRAIN_B = 3'd3,
        S_FLUSH   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic          slot_free;
    logic          a_pop;
    logic          b_pop;
    logic          match;
    logic          accept_start;
    logic [PW-1:0] product;

    // A pair may be loaded when the slot is empty or being drained this cycle
    assign slot_free    = !out_valid || out_ready;
    assign a_pop        = a_valid && a_ready;
    assign b_pop        = b_valid && b_ready;
    assign match        = (state == S_RUN) && a_pop && b_pop;
    assign accept_start = start && ((state == S_IDLE) || (state == S_DONE));
    assign product      = PW'(a_value) * PW'(b_value);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (a_pop && a_last && b_pop && b_last) begin
                    state_next = S_FLUSH;
                end else if (a_pop && a_last) begin
                    state_next = S_DRAIN_B;
                end else if (b_pop && b_last) begin
                    state_next = S_DRAIN_A;
                end
            end
            S_DRAIN_A: begin
                if (a_pop && a_last) begin
                    state_next = S_FLUSH;
                end
            end
            S_DRAIN_B: begin
                if (b_pop && b_last) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (slot_free) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Pop decisions: smaller head is discarded, equal heads pop together only if the slot is free
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (state)
            S_RUN: begin
                if (a_valid && b_valid) begin
                    if (a_coord < b_coord) begin
                        a_ready = 1'b1;
                    end else if (a_coord > b_coord) begin
                        b_ready = 1'b1;
                    end else if (slot_free) begin
                        a_ready = 1'b1;
                        b_ready = 1'b1;
                    end
                end
            end
            S_DRAIN_A: a_ready = a_valid;
            S_DRAIN_B: b_ready = b_valid;
            default: begin
                a_ready = 1'b0;
                b_ready = 1'b0;
            end
        endcase
    end

    // Output slot, accumulator, match counter and done flag
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_coord   <= '0;
            out_a_value <= '0;
            out_b_value <= '0;
            dot_sum     <= '0;
            match_count <= '0;
            done        <= 1'b0;
        end else begin
            if (match) begin
                out_valid   <= 1'b1;
                out_coord   <= a_coord;
                out_a_value <= a_value;
                out_b_value <= b_value;
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end

            if (accept_start) begin
                dot_sum     <= '0;
                match_count <= '0;
                done        <= 1'b0;
            end else if (match) begin
                dot_sum     <= dot_sum + ACCW'(product);
                match_count <= match_count + CNTW'(1);
            end

            if ((state == S_FLUSH) && slot_free) begin
                done <= 1'b1;
            end
        end
    end

endmodule
